// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit
// Shift-add multiply and restoring divide, one bit per cycle, with done pulse and busy stall.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  fn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc;
  logic        neg_main;
  logic        neg_rem;

  logic        is_div, sa_in, sb_in, div_zero, div_ovf, special;
  logic [31:0] abs_a, abs_b, special_res;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quo, rem, fin_res;

  always_comb begin
    is_div      = i_funct3[2];
    sa_in       = i_a[31] & (i_funct3 == 3'b001 || i_funct3 == 3'b010 ||
                             i_funct3 == 3'b100 || i_funct3 == 3'b110);
    sb_in       = i_b[31] & (i_funct3 == 3'b001 || i_funct3 == 3'b100 ||
                             i_funct3 == 3'b110);
    abs_a       = sa_in ? -i_a : i_a;
    abs_b       = sb_in ? -i_b : i_b;
    div_zero    = is_div && (i_b == 32'd0);
    div_ovf     = is_div && !i_funct3[0] && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    special     = div_zero || div_ovf;
    special_res = 32'd0;
    if (div_zero)
      special_res = i_funct3[1] ? i_a : 32'hFFFF_FFFF;
    else if (div_ovf)
      special_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, b_mag};
    div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                             : {div_diff[31:0],  acc[30:0], 1'b1};
    prod      = neg_main ? -mul_next : mul_next;
    quo       = neg_main ? -div_next[31:0] : div_next[31:0];
    rem       = neg_rem  ? -div_next[63:32] : div_next[63:32];
    case (fn)
      3'b000:                 fin_res = prod[31:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[63:32];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      fn       <= 3'd0;
      a_mag    <= 32'd0;
      b_mag    <= 32'd0;
      acc      <= 64'd0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_valid) begin
            fn     <= i_funct3;
            o_busy <= 1'b1;
            if (special) begin
              o_result <= special_res;
              o_done   <= 1'b1;
              state    <= FIN;
            end else begin
              a_mag    <= abs_a;
              b_mag    <= abs_b;
              acc      <= is_div ? {32'd0, abs_a} : {32'd0, abs_b};
              neg_main <= sa_in ^ sb_in;
              neg_rem  <= sa_in;
              cnt      <= 6'd0;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          acc <= fn[2] ? div_next : mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            o_result <= fin_res;
            o_done   <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          cnt    <= 6'd0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
// Directed vector table, hand-written multi-cycle sequences and a reference-model sweep.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [2:0]  i_funct3;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_funct3(i_funct3),
    .i_a(i_a), .i_b(i_b), .i_flush(i_flush),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 32'd0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Issue one op, then follow it cycle by cycle (n = cycles after the accept edge).
  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    int done_n;
    logic busy_bad;
    logic [31:0] r;
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = f; i_a = a; i_b = b;
    @(posedge clk);
    #1 i_valid = 1'b0;
    done_n = 0; busy_bad = 1'b0; r = 32'd0;
    for (n = 1; n <= 40 && done_n == 0; n++) begin
      @(negedge clk);
      if (!o_busy) busy_bad = 1'b1;
      if (o_done) begin done_n = n; r = o_result; end
    end
    check({nm, " latency"}, 32'(done_n), 32'(lat));
    check({nm, " result"}, r, exp);
    check({nm, " busy"}, {31'd0, busy_bad}, 32'd0);
    @(negedge clk);
    check({nm, " idle"}, {30'd0, o_busy, o_done}, 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    int dn;
    logic [31:0] r;
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [31:0] picks[6];

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'b111, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};

    rst = 1'b1; i_valid = 1'b0; i_funct3 = 3'd0; i_a = 32'd0; i_b = 32'd0; i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset done", {31'd0, o_done}, 32'd0);
    check("reset result", o_result, 32'd0);

    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    do_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Request while busy is dropped, not queued.
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = 3'b000; i_a = 32'd7; i_b = 32'hFFFF_FFFD;
    @(posedge clk);
    #1 i_valid = 1'b0;
    dones = 0; dn = 0; r = 32'd0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5) begin i_valid = 1'b1; i_funct3 = 3'b101; i_a = 32'd100; i_b = 32'd7; end
      else i_valid = 1'b0;
      if (o_done) begin dones++; dn = n; r = o_result; end
    end
    i_valid = 1'b0;
    check("ignored dones", 32'(dones), 32'd1);
    check("ignored latency", 32'(dn), 32'd33);
    check("ignored result", r, 32'hFFFF_FFEB);

    // Flush mid-operation keeps the previous result and produces no done.
    do_op("pre-flush", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = 3'b100; i_a = 32'd100; i_b = 32'd7;
    @(posedge clk);
    #1 i_valid = 1'b0;
    dones = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      i_flush = (n == 10);
      if (n == 11) begin
        check("flush busy", {31'd0, o_busy}, 32'd0);
        check("flush result", o_result, 32'hFFFF_FFFD);
      end
      if (o_done) dones++;
    end
    i_flush = 1'b0;
    check("flush dones", 32'(dones), 32'd0);

    // Flush outranks a same-cycle request.
    @(negedge clk);
    i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'b000; i_a = 32'd3; i_b = 32'd3;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush vs valid busy", {31'd0, o_busy}, 32'd0);

    // Reset mid-operation clears everything.
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = 3'b100; i_a = 32'd100; i_b = 32'd7;
    @(posedge clk);
    #1 i_valid = 1'b0;
    dones = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      rst = (n == 10);
      if (n == 11)
        check("rst outputs", {o_busy, o_done, o_result[29:0]} | {31'd0, |o_result[31:30]}, 32'd0);
      if (o_done) dones++;
    end
    rst = 1'b0;
    check("rst dones", 32'(dones), 32'd0);

    // Reference-model sweep over all funct3 values with corner operands mixed in.
    picks[0] = 32'd0; picks[1] = 32'd1; picks[2] = 32'hFFFF_FFFF;
    picks[3] = 32'h8000_0000; picks[4] = 32'h7FFF_FFFF; picks[5] = 32'd0;
    for (int k = 0; k < 200; k++) begin
      f = 3'($urandom_range(0, 7));
      picks[5] = $urandom;
      a = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 4)] : picks[5];
      picks[5] = $urandom;
      b = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 4)] : picks[5];
      do_op($sformatf("rand%0d f=%0d a=%h b=%h", k, f, a, b), f, a, b, ref_res(f, a, b), ref_lat(f, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
